// File: rtl/bf16_mul_vec.sv
// Vector of independent bf16 multipliers, exact (truncating) or L-Mul approximate,
// behind a 3-stage valid/ready pipeline (decode, mantissa multiply/add, normalise/pack).
module bf16_mul_vec #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned LMUL_OFS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  i_mode,
  input  logic [16*LANES-1:0]   i_a,
  input  logic [16*LANES-1:0]   i_b,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [16*LANES-1:0]   o_p
);

  logic v1, v2, v3;
  logic m1, m2;
  logic in_rst;
  logic en1, en2, en3;
  logic take;

  // A stage may load when it is empty or its contents move on this cycle.
  assign en3     = !v3 || o_ready;
  assign en2     = !v2 || en3;
  assign en1     = !v1 || en2;
  assign i_ready = !in_rst && en1;
  assign take    = i_valid && i_ready;
  assign o_valid = v3;

  always_ff @(posedge clk) begin
    in_rst <= rst;
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= take;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (take)      m1 <= i_mode;
    if (en2 && v1) m2 <= m1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [15:0] a, b;
    logic [7:0]  ea, eb;
    logic [6:0]  ma, mb;
    logic        az, bz, ai, bi, an, bn;
    logic        sgn;
    logic        sp_d;
    logic [15:0] spv_d;

    assign a   = i_a[16*k +: 16];
    assign b   = i_b[16*k +: 16];
    assign ea  = a[14:7];
    assign eb  = b[14:7];
    assign ma  = a[6:0];
    assign mb  = b[6:0];
    assign sgn = a[15] ^ b[15];
    assign az  = (ea == 8'd0);
    assign bz  = (eb == 8'd0);
    assign ai  = (ea == 8'hFF) && (ma == 7'd0);
    assign bi  = (eb == 8'hFF) && (mb == 7'd0);
    assign an  = (ea == 8'hFF) && (ma != 7'd0);
    assign bn  = (eb == 8'hFF) && (mb != 7'd0);

    always_comb begin
      sp_d  = 1'b0;
      spv_d = '0;
      if (an || bn || (ai && bz) || (bi && az)) begin
        sp_d  = 1'b1;
        spv_d = 16'h7FC0;
      end else if (ai || bi) begin
        sp_d  = 1'b1;
        spv_d = {sgn, 15'h7F80};
      end else if (az || bz) begin
        sp_d  = 1'b1;
        spv_d = {sgn, 15'h0000};
      end
    end

    // S1: decoded operands and special-case result
    logic              s1_sgn, s1_sp;
    logic [15:0]       s1_spv;
    logic signed [9:0] s1_e;
    logic [6:0]        s1_ma, s1_mb;

    always_ff @(posedge clk) begin
      if (take) begin
        s1_sgn <= sgn;
        s1_sp  <= sp_d;
        s1_spv <= spv_d;
        s1_e   <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        s1_ma  <= ma;
        s1_mb  <= mb;
      end
    end

    // S2: full product (exact) or offset mantissa sum (L-Mul) in a shared 16-bit field
    logic [15:0]       prod_d;
    logic              s2_sgn, s2_sp;
    logic [15:0]       s2_spv;
    logic signed [9:0] s2_e;
    logic [15:0]       s2_prod;

    always_comb begin
      prod_d = '0;
      if (m1)
        prod_d = {7'd0, 9'({2'b00, s1_ma}) + 9'({2'b00, s1_mb}) + 9'(LMUL_OFS)};
      else
        prod_d = 16'({1'b1, s1_ma}) * 16'({1'b1, s1_mb});
    end

    always_ff @(posedge clk) begin
      if (en2 && v1) begin
        s2_sgn  <= s1_sgn;
        s2_sp   <= s1_sp;
        s2_spv  <= s1_spv;
        s2_e    <= s1_e;
        s2_prod <= prod_d;
      end
    end

    // S3: normalise, range-check exponent, pack
    logic              hi;
    logic signed [9:0] e_n;
    logic [6:0]        mant;
    logic [15:0]       res_d;
    logic [15:0]       s3_p;

    always_comb begin
      hi    = m2 ? (s2_prod[8] | s2_prod[7]) : s2_prod[15];
      e_n   = hi ? s2_e + 10'sd1 : s2_e;
      mant  = '0;
      res_d = '0;
      if (m2)
        mant = hi ? 7'((s2_prod[8:0] - 9'd128) >> 1) : s2_prod[6:0];
      else
        mant = hi ? s2_prod[14:8] : s2_prod[13:7];
      if (s2_sp)
        res_d = s2_spv;
      else if (e_n >= 10'sd255)
        res_d = {s2_sgn, 15'h7F80};
      else if (e_n <= 10'sd0)
        res_d = {s2_sgn, 15'h0000};
      else
        res_d = {s2_sgn, e_n[7:0], mant};
    end

    always_ff @(posedge clk) begin
      if (rst)
        s3_p <= '0;
      else if (en3 && v2)
        s3_p <= res_d;
    end

    assign o_p[16*k +: 16] = s3_p;
  end

endmodule

// File: tb/tb_bf16_mul_vec.sv
// Scoreboard bench for bf16_mul_vec: directed cases, backpressure, reset and a random stream.
module tb_bf16_mul_vec;
  localparam int L = 4;
  localparam int W = 16 * L;

  logic         clk, rst, i_valid, i_ready, i_mode, o_valid, o_ready;
  logic [W-1:0] i_a, i_b, o_p;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb[$];

  logic         acc, got, ir, ov;
  logic [W-1:0] p;

  bf16_mul_vec #(.LANES(L), .LMUL_OFS(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_mode(i_mode),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_ready(o_ready), .o_p(o_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic md);
    int ea, eb, ma, mb, e, pr, s, mant;
    logic sg;
    bit az, bz, ai, bi, an, bn;
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = int'(a[6:0]);  mb = int'(b[6:0]);
    sg = a[15] ^ b[15];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 255 && ma == 0); bi = (eb == 255 && mb == 0);
    an = (ea == 255 && ma != 0); bn = (eb == 255 && mb != 0);
    if (an || bn || (ai && bz) || (bi && az)) return 16'h7FC0;
    if (ai || bi) return {sg, 15'h7F80};
    if (az || bz) return {sg, 15'h0000};
    e = ea + eb - 127;
    if (!md) begin
      pr = (128 + ma) * (128 + mb);
      if (pr >= 32768) begin e++; mant = (pr / 256) % 128; end
      else mant = (pr / 128) % 128;
    end else begin
      s = ma + mb + 8;
      if (s >= 128) begin e++; mant = (s - 128) / 2; end
      else mant = s;
    end
    if (e >= 255) return {sg, 15'h7F80};
    if (e <= 0) return {sg, 15'h0000};
    return {sg, 8'(e), 7'(mant)};
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic md);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[16*k +: 16] = ref_mul(a[16*k +: 16], b[16*k +: 16], md);
    return r;
  endfunction

  function automatic logic [W-1:0] rep(input logic [15:0] x);
    return {L{x}};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: ;
      1: v[14:7] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      2: v[14:7] = 8'($urandom_range(190, 254));
      3: v[14:7] = 8'($urandom_range(1, 64));
      default: v[14:7] = 8'($urandom_range(100, 160));
    endcase
    return v;
  endfunction

  task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic md, input logic ordy);
    @(negedge clk);
    i_valid = iv; i_a = a; i_b = b; i_mode = md; o_ready = ordy;
    #1;
    acc = i_valid && i_ready;
    got = o_valid && o_ready;
    ir  = i_ready;
    ov  = o_valid;
    p   = o_p;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i_mode = 1'b0; i_a = '0; i_b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
    total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL reset_i_ready got=%b want=0", i_ready); end
    total++; if (o_p !== '0) begin bad++; $display("FAIL reset_o_p got=%h want=0", o_p); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_release_i_ready got=%b want=1", i_ready); end
  endtask

  task automatic test_single(input logic md);
    logic [15:0] ops[2];
    logic [15:0] exp_e[2];
    logic [15:0] exp_l[2];
    int lat;
    bit seen;
    ops = '{16'h3F80, 16'h3FC0};
    exp_e = '{16'h3F80, 16'h4010};
    exp_l = '{16'h3F88, 16'h4004};
    for (int n = 0; n < 2; n++) begin
      step(1'b1, rep(ops[n]), rep(ops[n]), md, 1'b1);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept mode=%0d got=%b want=1", md, acc); end
      sb.push_back(rep(md ? exp_l[n] : exp_e[n]));
      lat = 0; seen = 0;
      while (!seen && lat < 12) begin
        step(1'b0, '0, '0, 1'b0, 1'b1);
        lat++;
        if (got) begin
          seen = 1;
          total++;
          if (sb.size() == 0 || p !== sb[0]) begin
            bad++; $display("FAIL single_value mode=%0d got=%h want=%h", md, p, (sb.size() != 0) ? sb[0] : '0);
          end
          if (sb.size() != 0) void'(sb.pop_front());
        end
      end
      total++; if (lat != 3) begin bad++; $display("FAIL single_latency mode=%0d got=%0d want=3", md, lat); end
    end
  endtask

  task automatic test_interleave();
    logic       md[3];
    logic [15:0] ex[3];
    int oc[$];
    md = '{1'b0, 1'b1, 1'b0};
    ex = '{16'h4010, 16'h4004, 16'h4010};
    for (int n = 0; n < 3; n++) begin
      step(1'b1, rep(16'h3FC0), rep(16'h3FC0), md[n], 1'b1);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL interleave_accept beat=%0d got=%b want=1", n, acc); end
      sb.push_back(rep(ex[n]));
      if (got) oc.push_back(n);
    end
    for (int c = 3; c < 15 && sb.size() != 0; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (got) begin
        oc.push_back(c);
        total++;
        if (p !== sb[0]) begin bad++; $display("FAIL interleave_value got=%h want=%h", p, sb[0]); end
        void'(sb.pop_front());
      end
    end
    total++;
    if (oc.size() != 3 || oc[0] != 3 || oc[1] != 4 || oc[2] != 5) begin
      bad++; $display("FAIL interleave_timing got_count=%0d want=3 at cycles 3,4,5", oc.size());
    end
    sb.delete();
  endtask

  task automatic test_specials();
    logic [W-1:0] a, b, ex;
    int n_out;
    a  = {16'h0080, 16'h7F00, 16'hFF80, 16'h7F80};
    b  = {16'h0080, 16'h7F00, 16'h3F80, 16'h0000};
    ex = {16'h0000, 16'h7F80, 16'hFF80, 16'h7FC0};
    for (int m = 0; m < 2; m++) begin
      step(1'b1, a, b, m[0], 1'b1);
      if (acc) sb.push_back(ex);
    end
    n_out = 0;
    for (int c = 0; c < 12 && sb.size() != 0; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (got) begin
        n_out++;
        total++;
        if (p !== sb[0]) begin bad++; $display("FAIL specials got=%h want=%h", p, sb[0]); end
        void'(sb.pop_front());
      end
    end
    total++; if (n_out != 2) begin bad++; $display("FAIL specials_count got=%0d want=2", n_out); end
    sb.delete();
  endtask

  task automatic test_backpressure();
    int n_acc, n_out;
    logic [W-1:0] hold, a, b;
    n_acc = 0; hold = '0;
    for (int c = 0; c < 6; c++) begin
      a = {L{16'h3F80 + 16'(c)}};
      b = {L{16'h4000 + 16'(3 * c)}};
      step(1'b1, a, b, c[0], 1'b0);
      if (acc) begin n_acc++; sb.push_back(ref_vec(a, b, c[0])); end
      total++;
      if (ir !== ((c < 3) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL bp_i_ready cycle=%0d got=%b want=%b", c, ir, (c < 3) ? 1'b1 : 1'b0);
      end
      if (c == 3) hold = p;
      if (c > 3) begin
        total++;
        if (ov !== 1'b1 || p !== hold) begin bad++; $display("FAIL bp_stable cycle=%0d got=%h want=%h", c, p, hold); end
      end
    end
    total++; if (n_acc != 3) begin bad++; $display("FAIL bp_accepted got=%0d want=3", n_acc); end
    n_out = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (got) begin
        n_out++;
        total++;
        if (sb.size() == 0 || p !== sb[0]) begin bad++; $display("FAIL bp_drain got=%h", p); end
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
    total++; if (n_out != 3) begin bad++; $display("FAIL bp_drain_count got=%0d want=3", n_out); end
    sb.delete();
  endtask

  task automatic test_random();
    int sent, cyc;
    logic [W-1:0] a, b;
    logic md, iv;
    sent = 0; cyc = 0;
    while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
      for (int k = 0; k < L; k++) begin
        a[16*k +: 16] = rnd_op();
        b[16*k +: 16] = rnd_op();
      end
      md = 1'($urandom_range(0, 1));
      iv = (sent < 10000) && ($urandom_range(0, 3) != 0);
      step(iv, a, b, md, $urandom_range(0, 3) != 0);
      cyc++;
      if (acc) begin sent++; sb.push_back(ref_vec(a, b, md)); end
      if (got) begin
        total++;
        if (sb.size() == 0 || p !== sb[0]) begin
          bad++; $display("FAIL random got=%h want=%h", p, (sb.size() != 0) ? sb[0] : '0);
        end
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
    total++;
    if (cyc >= 60000) begin bad++; $display("FAIL random_timeout sent=%0d pending=%0d", sent, sb.size()); end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    int n_out;
    logic [W-1:0] a;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, rep(16'h4000 + 16'(c)), rep(16'h3F80), 1'b0, 1'b0);
      if (acc) sb.push_back(rep(16'h4000 + 16'(c)));
    end
    @(negedge clk); rst = 1'b1; i_valid = 1'b0; o_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_o_valid got=%b want=0", o_valid); end
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL midrst_i_ready got=%b want=1", i_ready); end
    for (int c = 0; c < 2; c++) begin
      a = rep(16'h3FC0 + 16'(c));
      step(1'b1, a, a, 1'b1, 1'b1);
      if (acc) sb.push_back(ref_vec(a, a, 1'b1));
    end
    n_out = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (got) begin
        n_out++;
        total++;
        if (sb.size() == 0 || p !== sb[0]) begin bad++; $display("FAIL midrst_value got=%h", p); end
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end
    total++; if (n_out != 2) begin bad++; $display("FAIL midrst_count got=%0d want=2", n_out); end
  endtask

  initial begin
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_interleave();
    test_specials();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
